// File: rtl/touch_pkg.sv
// Shared constants and FSM state encoding for the touch panel scan controller.
package touch_pkg;

    localparam logic [7:0] CMD_X          = 8'hD0;
    localparam logic [7:0] CMD_Y          = 8'h90;
    localparam int         FRAME_SCLKS    = 24;
    localparam int         RES_FIRST_EDGE = 10;
    localparam int         RES_BITS       = 12;
    // Setup half, 48 SCLK halves, trailing select-high half.
    localparam int         FRAME_HALVES   = 2 * FRAME_SCLKS + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_FRAME_X,
        S_FRAME_Y,
        S_CHECK,
        S_OUTPUT,
        S_HOLDOFF
    } state_t;

endpackage

// File: rtl/touch_scan_ctrl_if.sv
// Panel pins plus the coordinate result port of the touch scan controller.
interface touch_scan_ctrl_if;
    import touch_pkg::*;

    logic                enable;
    logic                pen_irq_n;
    logic                miso;
    logic                mosi;
    logic                sclk;
    logic                ss_n;
    logic [RES_BITS-1:0] x_pos;
    logic [RES_BITS-1:0] y_pos;
    logic                pos_valid;
    logic                pen_down;

    modport master (
        input  enable, pen_irq_n, miso,
        output mosi, sclk, ss_n, x_pos, y_pos, pos_valid, pen_down
    );

    modport slave (
        output enable, pen_irq_n, miso,
        input  mosi, sclk, ss_n, x_pos, y_pos, pos_valid, pen_down
    );

endinterface

// File: rtl/touch_spi_frame.sv
// 24-SCLK SPI mode-0 frame engine: 8-bit command out, 12-bit result in; done pulses CLK_DIV cycles after ss_n rises.
// Frame takes 51*CLK_DIV cycles from start to done; start is ignored while busy (no queueing).
module touch_spi_frame
    import touch_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          cmd,
    input  logic                miso,
    output logic                busy,
    output logic                done,
    output logic [RES_BITS-1:0] result,
    output logic                sclk,
    output logic                mosi,
    output logic                ss_n
);
    localparam int          DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [5:0]  H_LAST    = 6'(FRAME_HALVES);
    localparam logic [5:0]  H_SAMP_LO = 6'(2 * RES_FIRST_EDGE);
    localparam logic [5:0]  H_SAMP_HI = 6'(2 * (RES_FIRST_EDGE + RES_BITS - 1));

    logic [DW-1:0]          div;
    logic [5:0]             hcnt;
    logic [5:0]             hn;
    logic [FRAME_SCLKS-1:0] tx;
    logic                   wrap;

    assign wrap = (div == DW'(CLK_DIV - 1));
    assign hn   = hcnt + 6'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            div    <= '0;
            hcnt   <= '0;
            tx     <= '0;
            result <= '0;
            sclk   <= 1'b0;
            mosi   <= 1'b0;
            ss_n   <= 1'b1;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy   <= 1'b1;
                    div    <= '0;
                    hcnt   <= '0;
                    tx     <= {cmd, {(FRAME_SCLKS - 8){1'b0}}};
                    result <= '0;
                end
            end else if (!wrap) begin
                div <= div + DW'(1);
            end else begin
                div  <= '0;
                hcnt <= hn;
                // Sample at the end of the high phase so the synchronizer delay is absorbed.
                if (!hcnt[0] && hcnt >= H_SAMP_LO && hcnt <= H_SAMP_HI)
                    result <= {result[RES_BITS-2:0], miso};
                if (hcnt == H_LAST) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else if (hn == 6'd1) begin
                    ss_n <= 1'b0;
                    mosi <= tx[FRAME_SCLKS-1];
                end else if (hn == H_LAST) begin
                    ss_n <= 1'b1;
                    mosi <= 1'b0;
                end else if (!hn[0]) begin
                    sclk <= 1'b1;
                end else begin
                    sclk <= 1'b0;
                    mosi <= tx[FRAME_SCLKS-2];
                    tx   <= {tx[FRAME_SCLKS-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: rtl/touch_scan_ctrl.sv
// Touch scan sequencer: pen debounce, X/Y SPI frames, burst averaging when TOUCH_AVG_EN is defined.
// pos_valid fires 2 cycles after the final CHECK; no backpressure, the consumer must take each strobe.
module touch_scan_ctrl
    import touch_pkg::*;
#(
    parameter int CLK_DIV      = 25,
    parameter int DEBOUNCE_CYC = 50000,
    parameter int SCAN_GAP     = 250000,
    parameter int SAMPLES_LOG2 = 2
) (
    input  logic              clk,
    input  logic              reset,
    touch_scan_ctrl_if.master bus
);
    localparam int CNT_MAX = (DEBOUNCE_CYC > SCAN_GAP) ? DEBOUNCE_CYC : SCAN_GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t              state, next;
    logic [1:0]          pen_sync, miso_sync;
    logic                pen_up, miso_s;
    logic [CW-1:0]       cnt;
    logic                drop;
    logic [RES_BITS-1:0] x_raw, y_raw, x_pos, y_pos;
    logic                pos_valid, pen_down;
    logic                start_req, frame_start, frame_busy, frame_done;
    logic [7:0]          cmd;
    logic [RES_BITS-1:0] frame_result;
    logic                publish;

`ifdef TOUCH_AVG_EN
    localparam int ACC_W = RES_BITS + SAMPLES_LOG2;
    localparam int PW    = (SAMPLES_LOG2 > 0) ? SAMPLES_LOG2 : 1;

    logic [ACC_W-1:0] acc_x, acc_y;
    logic [PW-1:0]    pairs;
    logic             accept, last_pair;

    assign last_pair = (pairs == PW'((1 << SAMPLES_LOG2) - 1));
`endif

    assign pen_up      = pen_sync[1];
    assign miso_s      = miso_sync[1];
    assign frame_start = start_req && !frame_busy;

    assign bus.x_pos     = x_pos;
    assign bus.y_pos     = y_pos;
    assign bus.pos_valid = pos_valid;
    assign bus.pen_down  = pen_down;

    always_ff @(posedge clk) begin
        if (reset) begin
            pen_sync  <= 2'b11;
            miso_sync <= 2'b00;
        end else begin
            pen_sync  <= {pen_sync[0], bus.pen_irq_n};
            miso_sync <= {miso_sync[0], bus.miso};
        end
    end

    touch_spi_frame #(
        .CLK_DIV (CLK_DIV)
    ) u_frame (
        .clk    (clk),
        .reset  (reset),
        .start  (frame_start),
        .cmd    (cmd),
        .miso   (miso_s),
        .busy   (frame_busy),
        .done   (frame_done),
        .result (frame_result),
        .sclk   (bus.sclk),
        .mosi   (bus.mosi),
        .ss_n   (bus.ss_n)
    );

    always_comb begin
        next      = state;
        start_req = 1'b0;
        cmd       = CMD_X;
        publish   = 1'b0;
`ifdef TOUCH_AVG_EN
        accept    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (bus.enable && !pen_up)
                    next = S_DEBOUNCE;
            end
            S_DEBOUNCE: begin
                if (!bus.enable || pen_up) begin
                    next = S_IDLE;
                end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                    next      = S_FRAME_X;
                    start_req = 1'b1;
                end
            end
            S_FRAME_X: begin
                if (frame_done) begin
                    if (drop || !bus.enable) begin
                        next = S_IDLE;
                    end else begin
                        next      = S_FRAME_Y;
                        start_req = 1'b1;
                        cmd       = CMD_Y;
                    end
                end
            end
            S_FRAME_Y: begin
                if (frame_done)
                    next = (drop || !bus.enable) ? S_IDLE : S_CHECK;
            end
            S_CHECK: begin
                if (!bus.enable || pen_up) begin
                    next = S_IDLE;
                end else begin
`ifdef TOUCH_AVG_EN
                    accept = 1'b1;
                    if (last_pair) begin
                        next = S_OUTPUT;
                    end else begin
                        next      = S_FRAME_X;
                        start_req = 1'b1;
                    end
`else
                    next = S_OUTPUT;
`endif
                end
            end
            S_OUTPUT: begin
                if (!bus.enable) begin
                    next = S_IDLE;
                end else begin
                    publish = 1'b1;
                    next    = S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                if (!bus.enable || pen_up) begin
                    next = S_IDLE;
                end else if (cnt == CW'(SCAN_GAP - 1)) begin
                    next      = S_FRAME_X;
                    start_req = 1'b1;
                end
            end
            default: next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            drop      <= 1'b0;
            x_raw     <= '0;
            y_raw     <= '0;
            x_pos     <= '0;
            y_pos     <= '0;
            pos_valid <= 1'b0;
            pen_down  <= 1'b0;
        end else begin
            state     <= next;
            pos_valid <= 1'b0;
            if (next != state || (state != S_DEBOUNCE && state != S_HOLDOFF))
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
            // A frame in flight always finishes; remember the enable drop for its end.
            if (state == S_IDLE)
                drop <= 1'b0;
            else if ((state == S_FRAME_X || state == S_FRAME_Y) && !bus.enable)
                drop <= 1'b1;
            if (frame_done && state == S_FRAME_X)
                x_raw <= frame_result;
            if (frame_done && state == S_FRAME_Y)
                y_raw <= frame_result;
            if (publish) begin
`ifdef TOUCH_AVG_EN
                x_pos <= acc_x[ACC_W-1:SAMPLES_LOG2];
                y_pos <= acc_y[ACC_W-1:SAMPLES_LOG2];
`else
                x_pos <= x_raw;
                y_pos <= y_raw;
`endif
                pos_valid <= 1'b1;
                pen_down  <= 1'b1;
            end
            if (next == S_IDLE)
                pen_down <= 1'b0;
        end
    end

`ifdef TOUCH_AVG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_x <= '0;
            acc_y <= '0;
            pairs <= '0;
        end else if (publish || next == S_IDLE) begin
            acc_x <= '0;
            acc_y <= '0;
            pairs <= '0;
        end else if (accept) begin
            acc_x <= acc_x + ACC_W'(x_raw);
            acc_y <= acc_y + ACC_W'(y_raw);
            pairs <= pairs + PW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_touch_scan_ctrl.sv
// Directed bench for touch_scan_ctrl with a behavioural XPT2046-style panel model.
module tb_touch_scan_ctrl;
    import touch_pkg::*;

    localparam int CLK_DIV = 2;
    localparam int DEB     = 8;
    localparam int GAP     = 40;
    localparam int SL2     = 2;
`ifdef TOUCH_AVG_EN
    localparam int NP  = 1 << SL2;
    localparam bit AVG = 1'b1;
`else
    localparam int NP  = 1;
    localparam bit AVG = 1'b0;
`endif
    localparam int REL_PAIR = (NP < 3) ? NP : 3;

    typedef struct {
        logic [0:3][11:0] xs;
        logic [0:3][11:0] ys;
        logic [11:0]      ex_avg;
        logic [11:0]      ey_avg;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    touch_scan_ctrl_if bus();

    touch_scan_ctrl #(
        .CLK_DIV      (CLK_DIV),
        .DEBOUNCE_CYC (DEB),
        .SCAN_GAP     (GAP),
        .SAMPLES_LOG2 (SL2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Panel model: captures the command, answers with the next X/Y sample, audits frame shape.
    logic [0:3][11:0] mx, my;
    int xbase = 0, ybase = 0;
    logic sclk_q = 1'b0, ss_q = 1'b1;
    logic [7:0] rx_cmd = 8'h00;
    logic [11:0] data = 12'h000;
    int bitn = 0, low_cyc = 0;
    int frames_started = 0, frames_done = 0, bad_frames = 0;
    int xi = 0, yi = 0, pv_count = 0, sclk_rises = 0;

    always @(negedge clk) begin
        if (bus.pos_valid === 1'b1) pv_count++;
        if (bus.ss_n !== 1'b0) bus.miso = 1'b0;
        if (bus.ss_n === 1'b0 && ss_q) begin
            bitn = 0;
            rx_cmd = 8'h00;
            low_cyc = 0;
            frames_started++;
        end
        if (bus.ss_n === 1'b0) low_cyc++;
        if (bus.sclk === 1'b1 && !sclk_q) begin
            sclk_rises++;
            if (bus.ss_n === 1'b0) begin
                bitn++;
                if (bitn <= 8) rx_cmd = {rx_cmd[6:0], bus.mosi};
            end
        end
        if (bus.ss_n === 1'b0 && bus.sclk === 1'b0 && sclk_q) begin
            if (bitn == 8) data = (rx_cmd == CMD_X) ? mx[(xi - xbase) % 4] : my[(yi - ybase) % 4];
            if (bitn >= 9 && bitn <= 20) bus.miso = data[20 - bitn];
            else bus.miso = 1'b0;
        end
        if (bus.ss_n === 1'b1 && !ss_q) begin
            if (rx_cmd != ((frames_done % 2 == 0) ? CMD_X : CMD_Y) || bitn != FRAME_SCLKS ||
                low_cyc != 49 * CLK_DIV)
                bad_frames++;
            if (rx_cmd == CMD_X) xi++;
            else yi++;
            frames_done++;
        end
        sclk_q = (bus.sclk === 1'b1);
        ss_q   = (bus.ss_n !== 1'b0);
    end

    vec_t vecs [4];

    initial begin
        int n, s0, f0, b0, p0, r0;
        logic [11:0] ex, ey;

        vecs[0] = '{xs: '{12'd100, 12'd101, 12'd102, 12'd104},
                    ys: '{12'd4000, 12'd4000, 12'd4000, 12'd4000}, ex_avg: 12'd101, ey_avg: 12'd4000};
        vecs[1] = '{xs: '{12'h123, 12'h123, 12'h123, 12'h123},
                    ys: '{12'hABC, 12'hABC, 12'hABC, 12'hABC}, ex_avg: 12'h123, ey_avg: 12'hABC};
        vecs[2] = '{xs: '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF},
                    ys: '{12'd0, 12'd0, 12'd0, 12'd3}, ex_avg: 12'hFFF, ey_avg: 12'd0};
        vecs[3] = '{xs: '{12'd1, 12'd2, 12'd3, 12'd4},
                    ys: '{12'h800, 12'h801, 12'h7FF, 12'h800}, ex_avg: 12'd2, ey_avg: 12'h800};
        mx = vecs[0].xs;
        my = vecs[0].ys;

        bus.enable = 1'b0;
        bus.pen_irq_n = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ss_n", bus.ss_n, 1);
        check("rst_sclk", bus.sclk, 0);
        check("rst_mosi", bus.mosi, 0);
        check("rst_x_pos", bus.x_pos, 0);
        check("rst_y_pos", bus.y_pos, 0);
        check("rst_pos_valid", bus.pos_valid, 0);
        check("rst_pen_down", bus.pen_down, 0);
        check("rst_state", dut.state, S_IDLE);

        // Table of coordinate bursts, pen held until the result appears.
        for (int v = 0; v < 4; v++) begin
            mx = vecs[v].xs;
            my = vecs[v].ys;
            xbase = xi;
            ybase = yi;
            f0 = frames_done;
            b0 = bad_frames;
            p0 = pv_count;
            ex = AVG ? vecs[v].ex_avg : vecs[v].xs[0];
            ey = AVG ? vecs[v].ey_avg : vecs[v].ys[0];
            bus.enable = 1'b1;
            bus.pen_irq_n = 1'b0;
            n = 0;
            while (bus.pos_valid !== 1'b1 && n < 5000) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("vec%0d_pos_valid_seen", v), bus.pos_valid, 1);
            check($sformatf("vec%0d_x_pos", v), bus.x_pos, ex);
            check($sformatf("vec%0d_y_pos", v), bus.y_pos, ey);
            @(negedge clk);
            check($sformatf("vec%0d_strobe_one_cycle", v), bus.pos_valid, 0);
            check($sformatf("vec%0d_pen_down", v), bus.pen_down, 1);
            check($sformatf("vec%0d_frames", v), frames_done - f0, 2 * NP);
            check($sformatf("vec%0d_frame_shape_errors", v), bad_frames - b0, 0);
            bus.pen_irq_n = 1'b1;
            repeat (10) @(negedge clk);
            check($sformatf("vec%0d_pen_down_cleared", v), bus.pen_down, 0);
            check($sformatf("vec%0d_pos_valid_count", v), pv_count - p0, 1);
            check($sformatf("vec%0d_x_pos_held", v), bus.x_pos, ex);
            bus.enable = 1'b0;
            repeat (5) @(negedge clk);
        end

        // Pen bounce shorter than the debounce window.
        s0 = frames_started;
        bus.enable = 1'b1;
        bus.pen_irq_n = 1'b0;
        repeat (7) @(negedge clk);
        bus.pen_irq_n = 1'b1;
        repeat (60) @(negedge clk);
        check("bounce_no_frame", frames_started - s0, 0);
        check("bounce_state_idle", dut.state, S_IDLE);
        bus.enable = 1'b0;

        // Pen lifted during the Y frame of pair REL_PAIR.
        mx = vecs[0].xs;
        my = vecs[0].ys;
        xbase = xi;
        ybase = yi;
        s0 = frames_started;
        p0 = pv_count;
        bus.enable = 1'b1;
        bus.pen_irq_n = 1'b0;
        n = 0;
        while (frames_started - s0 < 2 * REL_PAIR && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("release_reached_frame", frames_started - s0, 2 * REL_PAIR);
        bus.pen_irq_n = 1'b1;
        repeat (200) @(negedge clk);
        check("release_no_pos_valid", pv_count - p0, 0);
        check("release_pen_down", bus.pen_down, 0);
        check("release_state_idle", dut.state, S_IDLE);
        check("release_no_more_frames", frames_started - s0, 2 * REL_PAIR);
        bus.enable = 1'b0;
        repeat (5) @(negedge clk);

        // enable dropped at SCLK edge 5 of the first Y frame.
        xbase = xi;
        ybase = yi;
        s0 = frames_started;
        b0 = bad_frames;
        p0 = pv_count;
        bus.enable = 1'b1;
        bus.pen_irq_n = 1'b0;
        n = 0;
        while (!(frames_started - s0 == 2 && bitn == 5) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("endrop_reached_edge5", bitn, 5);
        bus.enable = 1'b0;
        n = 0;
        while (bus.ss_n !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("endrop_frame_sclks", bitn, FRAME_SCLKS);
        check("endrop_frame_shape_errors", bad_frames - b0, 0);
        repeat (50) @(negedge clk);
        check("endrop_state_idle", dut.state, S_IDLE);
        check("endrop_no_pos_valid", pv_count - p0, 0);
        check("endrop_no_more_frames", frames_started - s0, 2);
        bus.pen_irq_n = 1'b1;
        repeat (5) @(negedge clk);

        // Synchronous reset held 5 cycles from SCLK edge 12 of a frame.
        s0 = frames_started;
        bus.enable = 1'b1;
        bus.pen_irq_n = 1'b0;
        n = 0;
        while (!(frames_started > s0 && bitn == 12) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("mreset_reached_edge12", bitn, 12);
        reset = 1'b1;
        bus.enable = 1'b0;
        @(negedge clk);
        check("mreset_ss_n", bus.ss_n, 1);
        check("mreset_sclk", bus.sclk, 0);
        check("mreset_mosi", bus.mosi, 0);
        check("mreset_pos_valid", bus.pos_valid, 0);
        check("mreset_pen_down", bus.pen_down, 0);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        r0 = sclk_rises;
        repeat (200) @(negedge clk);
        check("mreset_no_sclk", sclk_rises - r0, 0);
        check("mreset_state_idle", dut.state, S_IDLE);
        bus.pen_irq_n = 1'b1;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/touch_scan_ctrl.md
# touch_scan_ctrl

Autonomous scan sequencer for the resistive touch panel controller (ADS7843/XPT2046-class) on the SPI and pen-IRQ pins. Detects pen-down, runs X/Y conversion frames over its own SPI bit engine, optionally averages bursts, and presents 12-bit raw coordinates to the theremin UI logic with a one-cycle valid strobe. Replaces the CPU-polled SPI path, so the Nios core only reads finished coordinates.

## Interface
- CLK_DIV, 25: clk cycles per SCLK half-period (50 MHz gives 1 MHz SCLK); must be ≥ 2.
- DEBOUNCE_CYC, 50000: pen_irq_n must stay low this many cycles before the first frame.
- SCAN_GAP, 250000: idle cycles between scan bursts while the pen stays down.
- SAMPLES_LOG2, 2: log2 of X/Y pairs averaged per output (used only with TOUCH_AVG_EN).
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  scanning permitted
- pen_irq_n  in  1  panel pen interrupt, asynchronous, active-low
- miso  in  1  SPI data from panel
- mosi  out  1  SPI data to panel
- sclk  out  1  SPI clock, mode 0
- ss_n  out  1  SPI select, active-low
- x_pos  out  12  averaged raw X
- y_pos  out  12  averaged raw Y
- pos_valid  out  1  one-cycle strobe, x_pos/y_pos updated
- pen_down  out  1  level: pen confirmed down

## Operation
- Reset values: ss_n=1, sclk=0, mosi=0, x_pos=0, y_pos=0, pos_valid=0, pen_down=0, state IDLE.
- pen_irq_n and miso pass through a 2-FF synchronizer; all decisions use the synchronized pen signal.
- States: IDLE → DEBOUNCE → FRAME_X → FRAME_Y → CHECK → (ACCUM loop) → OUTPUT → HOLDOFF → FRAME_X.
- IDLE: wait for enable=1 and pen low. DEBOUNCE: count DEBOUNCE_CYC. Pen high before the count completes returns to IDLE. Completion goes to FRAME_X.
- FRAME_X sends command 0xD0. FRAME_Y sends command 0x90. Each frame is 24 SCLK periods, MSB first, command in SCLK 1–8.
- Result is the 12 bits sampled on SCLK rising edges 10–21, MSB first. All other received bits are ignored.
- CHECK: evaluated after ss_n has been high CLK_DIV cycles. Pen high means discard the burst, pen_down←0, go to IDLE. Pen low means add the pair to the accumulators.
- Another pair is needed when fewer than 2^SAMPLES_LOG2 pairs are accumulated; go to FRAME_X. Otherwise go to OUTPUT.
- OUTPUT: x_pos = accX >> SAMPLES_LOG2, y_pos likewise. Truncation, no rounding. Accumulators are (12+SAMPLES_LOG2) bits and cannot overflow. Then pos_valid=1 for one cycle, pen_down←1, accumulators clear.
- HOLDOFF: count SCAN_GAP. Pen high or enable=0 at any point means pen_down←0 and go to IDLE.
- enable=0 during DEBOUNCE, CHECK or OUTPUT returns to IDLE, discards partial accumulation, and suppresses pos_valid.
- enable=0 during a frame: the frame always completes, then the controller goes to IDLE.
- Reset mid-frame aborts the frame immediately (synchronous). Outputs take reset values on the next edge.

## Timing
- SPI mode 0: sclk idles low. mosi changes CLK_DIV cycles before each rising edge. miso is sampled on the rising edge.
- ss_n falls CLK_DIV cycles before the first rising SCLK edge. It rises CLK_DIV cycles after the last falling edge.
- ss_n stays high at least CLK_DIV cycles between frames.
- Frame = 50·CLK_DIV cycles, start to ss_n rise. Burst = 2^SAMPLES_LOG2 · 2 frames plus CHECK overhead.
- pos_valid is asserted 2 cycles after the CHECK that completes the burst. x_pos/y_pos are stable from that cycle until the next pos_valid.
- First-response latency from the pen_irq_n fall is roughly 2 + DEBOUNCE_CYC + burst time.

## Configuration
- TOUCH_AVG_EN defined: averaging as above; SAMPLES_LOG2 is honoured.
- TOUCH_AVG_EN undefined: one pair per output with no accumulators. x_pos/y_pos are loaded directly from the frame results; SAMPLES_LOG2 is ignored.

## Structure
- touch_pkg holds:
  - constants CMD_X=8'hD0, CMD_Y=8'h90, FRAME_SCLKS=24, RES_FIRST_EDGE=10, RES_BITS=12;
  - the state enum.
- Sub-module touch_spi_frame is the 24-clock frame engine:
  - inputs: start, cmd[7:0]
  - outputs: busy, done pulse, result[11:0]
  - owns sclk/mosi/ss_n and the CLK_DIV counter.
- The top level holds the FSM, synchronizers, debounce/gap counters and accumulators.

## Test plan
All scenarios use CLK_DIV=2, DEBOUNCE_CYC=8 and SCAN_GAP=40, with a behavioural panel model.
- Reset held 5 cycles mid-frame (SCLK edge 12) → next cycle ss_n=1, sclk=0, mosi=0, pos_valid=0, pen_down=0; no further SCLK edges.
- Pen low for 7 cycles then high → no ss_n fall, state stays IDLE.
- TOUCH_AVG_EN undefined, model X=0x123, Y=0xABC, pen held low → mosi frames carry 0xD0 then 0x90, 24 SCLKs each; pos_valid once with x_pos=0x123, y_pos=0xABC; pen_down=1.
- TOUCH_AVG_EN defined, SAMPLES_LOG2=2, X samples 100,101,102,104 and Y 4000×4 → x_pos=101, y_pos=4000, single pos_valid after 8 frames.
- Pen released before CHECK of pair 3 → no pos_valid, pen_down=0, state returns to IDLE.
- enable dropped at SCLK edge 5 of FRAME_Y → frame completes all 24 SCLKs, no pos_valid, IDLE afterwards.
